// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller and its neighbours.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } md_state_e;

  // Forwarding-select encodings, kept here so the forwarding unit shares them.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] rd,
    input logic [4:0] rs1,
    input logic [4:0] rs2,
    input logic       uses_rs1,
    input logic       uses_rs2
  );
    return mem_read && (rd != 5'd0) &&
           ((uses_rs1 && (rd == rs1)) || (uses_rs2 && (rd == rs2)));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-detection inputs and stall/flush controls between pipeline and controller.
interface pipeline_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [4:0]       ID_rs1, ID_rs2;
  logic             ID_UsesRs1, ID_UsesRs2;
  logic [4:0]       EX_rd;
  logic             EX_MemRead, EX_BranchTaken, EX_MulDiv;
  logic             MulDiv_Done, MEM_MemReq, dmem_ready;

  logic             PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
  logic             IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush;
  logic             MulDiv_Start;
  logic [CNT_W-1:0] Stall_Count, Flush_Count;
  logic             Mem_Timeout;

  modport master (
    output ID_rs1, ID_rs2, ID_UsesRs1, ID_UsesRs2, EX_rd, EX_MemRead,
           EX_BranchTaken, EX_MulDiv, MulDiv_Done, MEM_MemReq, dmem_ready,
    input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
           IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush,
           MulDiv_Start, Stall_Count, Flush_Count, Mem_Timeout
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_UsesRs1, ID_UsesRs2, EX_rd, EX_MemRead,
           EX_BranchTaken, EX_MulDiv, MulDiv_Done, MEM_MemReq, dmem_ready,
    output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
           IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, MEM_WB_Flush,
           MulDiv_Start, Stall_Count, Flush_Count, Mem_Timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use, taken branch, MUL/DIV handshake, data-memory wait.
// state      | meaning
// ST_RUN     | normal flow; load-use/branch/new MUL/DIV handled here
// ST_MD_WAIT | MUL/DIV started, front of pipe frozen until done
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic                clk,
  input logic                rst,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  md_state_e         state, state_nxt;
  logic              done_pending, release_md, flush_inc;
  logic              memfreeze, load_use, mem_timeout;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;

  assign memfreeze = hz.MEM_MemReq && !hz.dmem_ready;
  assign load_use  = load_use_hit(hz.EX_MemRead, hz.EX_rd, hz.ID_rs1, hz.ID_rs2,
                                  hz.ID_UsesRs1, hz.ID_UsesRs2);

  always_comb begin
    hz.PC_Write     = 1'b1;
    hz.IF_ID_Write  = 1'b1;
    hz.ID_EX_Write  = 1'b1;
    hz.EX_MEM_Write = 1'b1;
    hz.MEM_WB_Write = 1'b1;
    hz.IF_ID_Flush  = 1'b0;
    hz.ID_EX_Flush  = 1'b0;
    hz.EX_MEM_Flush = 1'b0;
    hz.MEM_WB_Flush = 1'b0;
    hz.MulDiv_Start = 1'b0;
    state_nxt       = state;
    release_md      = 1'b0;
    flush_inc       = 1'b0;

    if (rst) begin
      hz.PC_Write     = 1'b0;
      hz.IF_ID_Write  = 1'b0;
      hz.ID_EX_Write  = 1'b0;
      hz.EX_MEM_Write = 1'b0;
      hz.MEM_WB_Write = 1'b0;
      hz.IF_ID_Flush  = 1'b1;
      hz.ID_EX_Flush  = 1'b1;
      hz.EX_MEM_Flush = 1'b1;
      hz.MEM_WB_Flush = 1'b1;
    end else if (memfreeze) begin
      // Only WB drains; it takes a bubble while MEM waits on the memory.
      hz.PC_Write     = 1'b0;
      hz.IF_ID_Write  = 1'b0;
      hz.ID_EX_Write  = 1'b0;
      hz.EX_MEM_Write = 1'b0;
      hz.MEM_WB_Flush = 1'b1;
    end else if (state == ST_MD_WAIT) begin
      if (hz.MulDiv_Done || done_pending) begin
        release_md = 1'b1;
        state_nxt  = ST_RUN;
      end else begin
        hz.PC_Write     = 1'b0;
        hz.IF_ID_Write  = 1'b0;
        hz.ID_EX_Write  = 1'b0;
        hz.EX_MEM_Flush = 1'b1;
      end
    end else if (hz.EX_MulDiv) begin
      hz.MulDiv_Start = 1'b1;
      hz.PC_Write     = 1'b0;
      hz.IF_ID_Write  = 1'b0;
      hz.ID_EX_Write  = 1'b0;
      hz.EX_MEM_Flush = 1'b1;
      state_nxt       = ST_MD_WAIT;
    end else if (hz.EX_BranchTaken) begin
      // Wins over load-use: the ID instruction is on the wrong path anyway.
      hz.IF_ID_Flush = 1'b1;
      hz.ID_EX_Flush = 1'b1;
      flush_inc      = 1'b1;
    end else if (load_use) begin
      hz.PC_Write    = 1'b0;
      hz.IF_ID_Write = 1'b0;
      hz.ID_EX_Flush = 1'b1;
    end
  end

  always_comb begin
    wait_nxt = '0;
    if (memfreeze)
      wait_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      done_pending <= 1'b0;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      // Latch a done pulse that lands while memory holds the pipe.
      if (release_md)
        done_pending <= 1'b0;
      else if (memfreeze && (state == ST_MD_WAIT) && hz.MulDiv_Done)
        done_pending <= 1'b1;
      if (memfreeze && (wait_nxt == WAIT_MAX))
        mem_timeout <= 1'b1;
    end
  end

  assign hz.Mem_Timeout = mem_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!hz.PC_Write),
    .count (hz.Stall_Count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (hz.Flush_Count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a random run against a rule model.
module tb_pipeline_hazard_ctrl;
  localparam int TMO = 4;
  localparam int CW  = 3;
  localparam int CMAX = 7;

  // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB writes, IF_ID,ID_EX,EX_MEM,MEM_WB flushes, start}
  localparam logic [9:0] V_RST = 10'b00000_1111_0;
  localparam logic [9:0] V_DEF = 10'b11111_0000_0;
  localparam logic [9:0] V_LU  = 10'b00111_0100_0;
  localparam logic [9:0] V_BR  = 10'b11111_1100_0;
  localparam logic [9:0] V_MDS = 10'b00011_0010_1;
  localparam logic [9:0] V_MDW = 10'b00011_0010_0;
  localparam logic [9:0] V_MF  = 10'b00001_0001_0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_errors = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {hz.PC_Write, hz.IF_ID_Write, hz.ID_EX_Write, hz.EX_MEM_Write, hz.MEM_WB_Write,
            hz.IF_ID_Flush, hz.ID_EX_Flush, hz.EX_MEM_Flush, hz.MEM_WB_Flush, hz.MulDiv_Start};
  endfunction

  task automatic set_idle();
    hz.ID_rs1 = 5'd0; hz.ID_rs2 = 5'd0; hz.ID_UsesRs1 = 1'b0; hz.ID_UsesRs2 = 1'b0;
    hz.EX_rd = 5'd0; hz.EX_MemRead = 1'b0; hz.EX_BranchTaken = 1'b0; hz.EX_MulDiv = 1'b0;
    hz.MulDiv_Done = 1'b0; hz.MEM_MemReq = 1'b0; hz.dmem_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_idle();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    n_checks++;
    if (outs() !== V_RST) begin n_errors++; $display("FAIL reset_outs got %b want %b", outs(), V_RST); end
    n_checks++;
    if (hz.Stall_Count !== 3'd0 || hz.Flush_Count !== 3'd0 || hz.Mem_Timeout !== 1'b0) begin
      n_errors++; $display("FAIL reset_regs got %0d/%0d/%b want 0/0/0", hz.Stall_Count, hz.Flush_Count, hz.Mem_Timeout);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (outs() !== V_DEF) begin n_errors++; $display("FAIL idle_outs got %b want %b", outs(), V_DEF); end
  endtask

  task automatic test_load_use();
    hz.EX_MemRead = 1'b1; hz.EX_rd = 5'd5; hz.ID_rs2 = 5'd5; hz.ID_UsesRs2 = 1'b1;
    hz.ID_rs1 = 5'd3; hz.ID_UsesRs1 = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_LU) begin n_errors++; $display("FAIL load_use got %b want %b", outs(), V_LU); end
    tick();
    n_checks++;
    if (hz.Stall_Count !== 3'd1) begin n_errors++; $display("FAIL load_use_cnt got %0d want 1", hz.Stall_Count); end
    hz.EX_rd = 5'd0; hz.ID_rs2 = 5'd0;
    #1;
    n_checks++;
    if (outs() !== V_DEF) begin n_errors++; $display("FAIL load_use_rd0 got %b want %b", outs(), V_DEF); end
    tick();
    n_checks++;
    if (hz.Stall_Count !== 3'd1) begin n_errors++; $display("FAIL rd0_cnt got %0d want 1", hz.Stall_Count); end
    set_idle();
  endtask

  task automatic test_branch();
    hz.EX_MemRead = 1'b1; hz.EX_rd = 5'd7; hz.ID_rs1 = 5'd7; hz.ID_UsesRs1 = 1'b1;
    hz.EX_BranchTaken = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_BR) begin n_errors++; $display("FAIL branch got %b want %b", outs(), V_BR); end
    tick();
    n_checks++;
    if (hz.Flush_Count !== 3'd1 || hz.Stall_Count !== 3'd1) begin
      n_errors++; $display("FAIL branch_cnt got flush %0d stall %0d want 1/1", hz.Flush_Count, hz.Stall_Count);
    end
    set_idle();
  endtask

  task automatic test_muldiv();
    do_reset();
    hz.EX_MulDiv = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      hz.MulDiv_Done = (c == 4);
      #1;
      n_checks++;
      if (outs() !== (c == 0 ? V_MDS : (c == 4 ? V_DEF : V_MDW))) begin
        n_errors++; $display("FAIL muldiv_c%0d got %b", c, outs());
      end
      tick();
    end
    set_idle();
    #1;
    n_checks++;
    if (outs() !== V_DEF || hz.Stall_Count !== 3'd4) begin
      n_errors++; $display("FAIL muldiv_end got %b stall %0d want %b stall 4", outs(), hz.Stall_Count, V_DEF);
    end
  endtask

  task automatic test_done_in_freeze();
    do_reset();
    hz.EX_MulDiv = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_MDS) begin n_errors++; $display("FAIL dif_start got %b want %b", outs(), V_MDS); end
    tick();
    hz.MEM_MemReq = 1'b1; hz.dmem_ready = 1'b0; hz.MulDiv_Done = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if (outs() !== V_MF) begin n_errors++; $display("FAIL dif_freeze%0d got %b want %b", c, outs(), V_MF); end
      tick();
      hz.MulDiv_Done = 1'b0;
    end
    hz.dmem_ready = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_DEF) begin n_errors++; $display("FAIL dif_release got %b want %b", outs(), V_DEF); end
    tick();
    set_idle();
    #1;
    n_checks++;
    if (outs() !== V_DEF || hz.Stall_Count !== 3'd3) begin
      n_errors++; $display("FAIL dif_after got %b stall %0d want %b stall 3", outs(), hz.Stall_Count, V_DEF);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    hz.MEM_MemReq = 1'b1; hz.dmem_ready = 1'b0; hz.EX_BranchTaken = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (outs() !== V_MF) begin n_errors++; $display("FAIL tmo_freeze%0d got %b want %b", i, outs(), V_MF); end
      tick();
      n_checks++;
      if (hz.Mem_Timeout !== (i >= TMO - 1)) begin
        n_errors++; $display("FAIL tmo_flag%0d got %b want %b", i, hz.Mem_Timeout, (i >= TMO - 1));
      end
    end
    hz.dmem_ready = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_BR) begin n_errors++; $display("FAIL deferred_branch got %b want %b", outs(), V_BR); end
    tick();
    set_idle();
    #1;
    n_checks++;
    if (hz.Mem_Timeout !== 1'b1 || hz.Flush_Count !== 3'd1 || hz.Stall_Count !== 3'd6) begin
      n_errors++; $display("FAIL tmo_sticky got tmo %b flush %0d stall %0d want 1/1/6",
                           hz.Mem_Timeout, hz.Flush_Count, hz.Stall_Count);
    end
  endtask

  task automatic test_reset_in_md_wait();
    hz.EX_MulDiv = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_RST) begin n_errors++; $display("FAIL rst_mdw_outs got %b want %b", outs(), V_RST); end
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    n_checks++;
    if (outs() !== V_DEF || hz.Stall_Count !== 3'd0 || hz.Flush_Count !== 3'd0 || hz.Mem_Timeout !== 1'b0) begin
      n_errors++; $display("FAIL rst_mdw_after got %b %0d %0d %b want %b 0 0 0",
                           outs(), hz.Stall_Count, hz.Flush_Count, hz.Mem_Timeout, V_DEF);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    hz.EX_MemRead = 1'b1; hz.EX_rd = 5'd9; hz.ID_rs1 = 5'd9; hz.ID_UsesRs1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (hz.Stall_Count !== CW'((i + 1 > CMAX) ? CMAX : i + 1)) begin
        n_errors++; $display("FAIL sat%0d got %0d want %0d", i, hz.Stall_Count, (i + 1 > CMAX) ? CMAX : i + 1);
      end
    end
    set_idle();
  endtask

  task automatic test_random();
    bit m_md, m_pend, m_tmo, freeze, lu, relv;
    int m_wait, m_stall, m_flush;
    logic [9:0] exp;
    do_reset();
    m_md = 0; m_pend = 0; m_tmo = 0; m_wait = 0; m_stall = 0; m_flush = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      hz.ID_rs1 = 5'($urandom_range(0, 3)); hz.ID_rs2 = 5'($urandom_range(0, 3));
      hz.ID_UsesRs1 = 1'($urandom_range(0, 1)); hz.ID_UsesRs2 = 1'($urandom_range(0, 1));
      hz.EX_rd = 5'($urandom_range(0, 3));
      hz.EX_MemRead = ($urandom_range(0, 2) == 0);
      hz.EX_BranchTaken = ($urandom_range(0, 4) == 0);
      hz.EX_MulDiv = m_md ? 1'b1 : ($urandom_range(0, 5) == 0);
      hz.MulDiv_Done = m_md && ($urandom_range(0, 3) == 0);
      hz.MEM_MemReq = ($urandom_range(0, 2) == 0);
      hz.dmem_ready = ($urandom_range(0, 1) == 0);
      #1;
      freeze = hz.MEM_MemReq && !hz.dmem_ready;
      lu = hz.EX_MemRead && hz.EX_rd != 0 &&
           ((hz.ID_UsesRs1 && hz.EX_rd == hz.ID_rs1) || (hz.ID_UsesRs2 && hz.EX_rd == hz.ID_rs2));
      relv = m_md && (hz.MulDiv_Done || m_pend);
      if (freeze) exp = V_MF;
      else if (m_md) exp = relv ? V_DEF : V_MDW;
      else if (hz.EX_MulDiv) exp = V_MDS;
      else if (hz.EX_BranchTaken) exp = V_BR;
      else if (lu) exp = V_LU;
      else exp = V_DEF;
      n_checks++;
      if (outs() !== exp) begin n_errors++; $display("FAIL rand_outs cyc %0d got %b want %b", cyc, outs(), exp); end
      n_checks++;
      if (hz.Stall_Count !== CW'(m_stall) || hz.Flush_Count !== CW'(m_flush) || hz.Mem_Timeout !== m_tmo) begin
        n_errors++; $display("FAIL rand_regs cyc %0d got %0d/%0d/%b want %0d/%0d/%b", cyc,
                             hz.Stall_Count, hz.Flush_Count, hz.Mem_Timeout, m_stall, m_flush, m_tmo);
      end
      tick();
      if (!exp[9] && m_stall < CMAX) m_stall++;
      if (exp == V_BR && m_flush < CMAX) m_flush++;
      if (freeze) begin
        if (m_md && hz.MulDiv_Done) m_pend = 1;
        if (m_wait < TMO) m_wait++;
        if (m_wait == TMO) m_tmo = 1;
      end else begin
        m_wait = 0;
        if (relv) begin m_md = 0; m_pend = 0; end
        else if (!m_md && hz.EX_MulDiv) m_md = 1;
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_done_in_freeze();
    test_timeout();
    test_reset_in_md_wait();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
